dpd_fb_align: RTL and testbench



---
 rtl/dpd_fb_align_if.sv | 30 +++
 rtl/dpd_fb_align.sv | 221 ++++++++++++++++++++++
 tb/tb_dpd_fb_align.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpd_fb_align_if.sv
// Sample/handshake bundle between the DPD datapath and the feedback aligner.
// The master side drives tx/fb samples and start; the slave (aligner) drives results.
interface dpd_fb_align_if #(
  parameter int W     = 20,
  parameter int LAG_W = 6
);
  logic             start;
  logic [W-1:0]     tx_i;
  logic [W-1:0]     tx_q;
  logic [W-1:0]     fb_i;
  logic [W-1:0]     fb_q;
  logic [W-1:0]     ref_i;
  logic [W-1:0]     ref_q;
  logic [W-1:0]     fbo_i;
  logic [W-1:0]     fbo_q;
  logic [LAG_W-1:0] lag;
  logic             lock;
  logic             busy;
  logic             done;

  modport master (
    output start, tx_i, tx_q, fb_i, fb_q,
    input  ref_i, ref_q, fbo_i, fbo_q, lag, lock, busy, done
  );

  modport slave (
    input  start, tx_i, tx_q, fb_i, fb_q,
    output ref_i, ref_q, fbo_i, fbo_q, lag, lock, busy, done
  );
endinterface

// File: rtl/dpd_fb_align.sv
// Feedback-path aligner: captures one burst of tx/fb, finds the loop delay by complex
// cross-correlation over all candidate lags, and emits tx delayed to line up with fb.
module dpd_fb_align #(
  parameter int W        = 20,
  parameter int MAX_LAG  = 64,
  parameter int WIN      = 256,
  parameter int PEAK_MIN = 4096
) (
  input  logic           clk,
  input  logic           reset,
  dpd_fb_align_if.slave  bus
);
  localparam int LAG_W   = $clog2(MAX_LAG);
  localparam int WIN_W   = $clog2(WIN);
  localparam int CAP_LEN = WIN + MAX_LAG;
  localparam int CAP_W   = $clog2(CAP_LEN);
  localparam int STEP_W  = $clog2(WIN + 3);
  localparam int ACC_W   = 16 + WIN_W + 1;
  localparam int MET_W   = ACC_W + 1;

  localparam logic [CAP_W-1:0]  CAP_LAST  = CAP_W'(CAP_LEN - 1);
  localparam logic [CAP_W-1:0]  CAP_TX    = CAP_W'(WIN);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIN + 2);
  localparam logic [STEP_W-1:0] STEP_RD   = STEP_W'(WIN);
  localparam logic [LAG_W-1:0]  LAG_LAST  = LAG_W'(MAX_LAG - 1);
  localparam logic [MET_W-1:0]  PEAK_THR  = MET_W'(PEAK_MIN);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEARCH} state_t;

  state_t              state_q, state_d;
  logic [CAP_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [LAG_W-1:0]    cur_lag_q, cur_lag_d;
  logic                cap_we, rd_en, lag_end, search_enter, search_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cap_cnt_q <= '0;
      step_q    <= '0;
      cur_lag_q <= '0;
    end else begin
      state_q   <= state_d;
      cap_cnt_q <= cap_cnt_d;
      step_q    <= step_d;
      cur_lag_q <= cur_lag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cap_cnt_d    = cap_cnt_q;
    step_d       = step_q;
    cur_lag_d    = cur_lag_q;
    cap_we       = 1'b0;
    rd_en        = 1'b0;
    lag_end      = 1'b0;
    search_enter = 1'b0;
    search_end   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_CAPTURE;
          cap_cnt_d = '0;
        end
      end
      S_CAPTURE: begin
        cap_we    = 1'b1;
        cap_cnt_d = cap_cnt_q + 1'b1;
        if (cap_cnt_q == CAP_LAST) begin
          state_d      = S_SEARCH;
          search_enter = 1'b1;
          step_d       = '0;
          cur_lag_d    = '0;
        end
      end
      S_SEARCH: begin
        rd_en = (step_q < STEP_RD);
        if (step_q == STEP_LAST) begin
          lag_end   = 1'b1;
          step_d    = '0;
          cur_lag_d = cur_lag_q + 1'b1;
          if (cur_lag_q == LAG_LAST) begin
            search_end = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture buffers hold only the top 8 bits of I and Q, packed {I, Q}.
  logic [15:0] tx_buf [WIN];
  logic [15:0] fb_buf [CAP_LEN];
  logic [15:0] tx_rd_q, fb_rd_q;
  logic [15:0] tx_top, fb_top;
  logic [CAP_W-1:0] fb_rd_addr;

  assign tx_top     = {bus.tx_i[W-1 -: 8], bus.tx_q[W-1 -: 8]};
  assign fb_top     = {bus.fb_i[W-1 -: 8], bus.fb_q[W-1 -: 8]};
  assign fb_rd_addr = CAP_W'(step_q[WIN_W-1:0]) + CAP_W'(cur_lag_q);

  always_ff @(posedge clk) begin
    if (cap_we && (cap_cnt_q < CAP_TX)) tx_buf[cap_cnt_q[WIN_W-1:0]] <= tx_top;
    if (cap_we) fb_buf[cap_cnt_q] <= fb_top;
    tx_rd_q <= tx_buf[step_q[WIN_W-1:0]];
    fb_rd_q <= fb_buf[fb_rd_addr];
  end

  // tx * conj(fb) = (a+jb)(c-jd) = (ac+bd) + j(bc-ad)
  logic signed [16:0] ax, bx, cx, dx;
  logic signed [16:0] prod_re_q, prod_im_q;
  logic               rd_vld_q, mul_vld_q;
  logic signed [ACC_W-1:0] acc_re_q, acc_im_q;

  assign ax = {{9{tx_rd_q[15]}}, tx_rd_q[15:8]};
  assign bx = {{9{tx_rd_q[7]}},  tx_rd_q[7:0]};
  assign cx = {{9{fb_rd_q[15]}}, fb_rd_q[15:8]};
  assign dx = {{9{fb_rd_q[7]}},  fb_rd_q[7:0]};

  always_ff @(posedge clk) begin
    prod_re_q <= ax * cx + bx * dx;
    prod_im_q <= bx * cx - ax * dx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      mul_vld_q <= 1'b0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
    end else begin
      rd_vld_q  <= rd_en;
      mul_vld_q <= rd_vld_q;
      if (lag_end) begin
        acc_re_q <= '0;
        acc_im_q <= '0;
      end else if (mul_vld_q) begin
        acc_re_q <= acc_re_q + {{(ACC_W-17){prod_re_q[16]}}, prod_re_q};
        acc_im_q <= acc_im_q + {{(ACC_W-17){prod_im_q[16]}}, prod_im_q};
      end
    end
  end

  // The accumulator is complete on the last step of each lag; judge it there.
  logic [ACC_W-1:0] abs_re, abs_im;
  logic [MET_W-1:0] metric, best_q, fin_best;
  logic [LAG_W-1:0] best_lag_q, fin_lag, lag_q;
  logic             better, lock_q, done_q;

  assign abs_re   = acc_re_q[ACC_W-1] ? -acc_re_q : acc_re_q;
  assign abs_im   = acc_im_q[ACC_W-1] ? -acc_im_q : acc_im_q;
  assign metric   = {1'b0, abs_re} + {1'b0, abs_im};
  assign better   = (metric > best_q);
  assign fin_best = better ? metric : best_q;
  assign fin_lag  = better ? cur_lag_q : best_lag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      best_q     <= '0;
      best_lag_q <= '0;
      lag_q      <= '0;
      lock_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= search_end;
      if (search_enter) begin
        best_q     <= '0;
        best_lag_q <= '0;
      end else if (lag_end && better) begin
        best_q     <= metric;
        best_lag_q <= cur_lag_q;
      end
      if (search_end) begin
        if (fin_best >= PEAK_THR) begin
          lag_q  <= fin_lag;
          lock_q <= 1'b1;
        end else begin
          lock_q <= 1'b0;
        end
      end
    end
  end

  // Free-running alignment path: tap[k] is tx delayed by k cycles, packed {I, Q}.
  logic [2*W-1:0] tap  [MAX_LAG];
  logic [2*W-1:0] dl_q [MAX_LAG-1];
  logic [2*W-1:0] ref_q, fbo_q;

  assign tap[0] = {bus.tx_i, bus.tx_q};

  for (genvar gi = 0; gi < MAX_LAG - 1; gi++) begin : g_dl
    always_ff @(posedge clk) begin
      if (reset) dl_q[gi] <= '0;
      else       dl_q[gi] <= tap[gi];
    end
    assign tap[gi+1] = dl_q[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q <= '0;
      fbo_q <= '0;
    end else begin
      ref_q <= tap[lag_q];
      fbo_q <= {bus.fb_i, bus.fb_q};
    end
  end

  assign bus.ref_i = ref_q[2*W-1:W];
  assign bus.ref_q = ref_q[W-1:0];
  assign bus.fbo_i = fbo_q[2*W-1:W];
  assign bus.fbo_q = fbo_q[W-1:0];
  assign bus.lag   = lag_q;
  assign bus.lock  = lock_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_dpd_fb_align.sv
// Randomised bench for dpd_fb_align: a correlation model built from recorded input
// history predicts lag/lock/done/busy and the aligned outputs on every cycle.
module tb_dpd_fb_align;
  localparam int W          = 20;
  localparam int MAX_LAG    = 64;
  localparam int WIN        = 64;
  localparam int PEAK_MIN   = 4096;
  localparam int LAG_W      = $clog2(MAX_LAG);
  localparam int SEARCH_LAT = WIN + MAX_LAG + MAX_LAG * (WIN + 3);
  localparam int HMAX       = 65536;
  localparam int AMP        = 262144;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dpd_fb_align_if #(.W(W), .LAG_W(LAG_W)) bus ();

  dpd_fb_align #(
    .W(W), .MAX_LAG(MAX_LAG), .WIN(WIN), .PEAK_MIN(PEAK_MIN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus generator ----------------
  typedef enum {M_PRBS, M_ROT, M_ZERO, M_PER} mode_t;
  mode_t mode      = M_PRBS;
  int    dly       = 17;
  int    drv_n     = 0;
  logic  start_req = 1'b0;
  logic  rst_req   = 1'b1;
  logic  align_eq  = 1'b0;
  logic  chk_en    = 1'b0;
  logic [W-1:0] gi_h [HMAX];
  logic [W-1:0] gq_h [HMAX];

  function automatic logic [W-1:0] qpsk();
    int v;
    v = ($urandom_range(1) != 0) ? AMP : -AMP;
    v = v + int'($urandom_range(4095));
    return v[W-1:0];
  endfunction

  task automatic cyc(int n);
    int j, pv_i, pv_q;
    logic [W-1:0] fi, fq;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drv_n++;
      if (mode == M_PER) begin
        // Period-8 pattern: seven (+,+) symbols then one rotated (-,+) symbol.
        pv_i = ((drv_n % 8) == 7) ? -AMP : AMP;
        pv_q = AMP;
        gi_h[drv_n % HMAX] = pv_i[W-1:0];
        gq_h[drv_n % HMAX] = pv_q[W-1:0];
      end else begin
        gi_h[drv_n % HMAX] = qpsk();
        gq_h[drv_n % HMAX] = qpsk();
      end
      j = drv_n - dly;
      if (j > 0) begin
        fi = gi_h[j % HMAX];
        fq = gq_h[j % HMAX];
      end else begin
        fi = '0;
        fq = '0;
      end
      bus.tx_i = gi_h[drv_n % HMAX];
      bus.tx_q = gq_h[drv_n % HMAX];
      case (mode)
        M_ZERO:  begin bus.fb_i = '0;  bus.fb_q = '0; end
        M_ROT:   begin bus.fb_i = -fq; bus.fb_q = fi; end
        default: begin bus.fb_i = fi;  bus.fb_q = fq; end
      endcase
      bus.start = start_req;
      reset     = rst_req;
    end
  endtask

  // ---------------- behavioural model ----------------
  int     e         = 0;
  int     rst_edge  = 0;
  int     done_edge = -1;
  int     cap0      = 0;
  longint last_best = 0;
  logic [W-1:0] mt_i [HMAX];
  logic [W-1:0] mt_q [HMAX];
  logic [W-1:0] mf_i [HMAX];
  logic [W-1:0] mf_q [HMAX];
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic         exp_lock = 1'b0;
  int           exp_lag  = 0;
  logic [W-1:0] exp_ref_i = '0, exp_ref_q = '0, exp_fbo_i = '0, exp_fbo_q = '0;

  function automatic int top8(logic [W-1:0] v);
    logic signed [7:0] t;
    t = v[W-1 -: 8];
    return int'(t);
  endfunction

  // Exhaustive search over every lag using the recorded capture window.
  task automatic correlate(input int c0, output int best_lag, output longint best_m);
    longint re, im, m;
    int a, b, c, d;
    best_lag = 0;
    best_m   = 0;
    for (int l = 0; l < MAX_LAG; l++) begin
      re = 0;
      im = 0;
      for (int n = 0; n < WIN; n++) begin
        a  = top8(mt_i[(c0 + n) % HMAX]);
        b  = top8(mt_q[(c0 + n) % HMAX]);
        c  = top8(mf_i[(c0 + n + l) % HMAX]);
        d  = top8(mf_q[(c0 + n + l) % HMAX]);
        re = re + a * c + b * d;
        im = im + b * c - a * d;
      end
      m = ((re < 0) ? -re : re) + ((im < 0) ? -im : im);
      if (m > best_m) begin
        best_m   = m;
        best_lag = l;
      end
    end
  endtask

  always @(posedge clk) begin
    int pl, bl;
    longint bm;
    logic [W-1:0] ri, rq;
    e++;
    mt_i[e % HMAX] = bus.tx_i;
    mt_q[e % HMAX] = bus.tx_q;
    mf_i[e % HMAX] = bus.fb_i;
    mf_q[e % HMAX] = bus.fb_q;
    pl = exp_lag;
    exp_done <= 1'b0;
    if (reset) begin
      rst_edge = e;
      exp_busy  <= 1'b0;
      exp_lag   <= 0;
      exp_lock  <= 1'b0;
      exp_ref_i <= '0;
      exp_ref_q <= '0;
      exp_fbo_i <= '0;
      exp_fbo_q <= '0;
    end else begin
      if (e - pl > rst_edge) begin
        ri = mt_i[(e - pl) % HMAX];
        rq = mt_q[(e - pl) % HMAX];
      end else begin
        ri = '0;
        rq = '0;
      end
      exp_ref_i <= ri;
      exp_ref_q <= rq;
      exp_fbo_i <= bus.fb_i;
      exp_fbo_q <= bus.fb_q;
      if (!exp_busy && bus.start) begin
        exp_busy <= 1'b1;
        cap0      = e + 1;
        done_edge = e + SEARCH_LAT;
      end else if (exp_busy && e == done_edge) begin
        correlate(cap0, bl, bm);
        last_best = bm;
        exp_busy <= 1'b0;
        exp_done <= 1'b1;
        if (bm >= PEAK_MIN) begin
          exp_lag  <= bl;
          exp_lock <= 1'b1;
        end else begin
          exp_lock <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",  longint'(bus.busy),  longint'(exp_busy));
      check("done",  longint'(bus.done),  longint'(exp_done));
      check("lag",   longint'(bus.lag),   longint'(exp_lag));
      check("lock",  longint'(bus.lock),  longint'(exp_lock));
      check("ref_i", longint'(bus.ref_i), longint'(exp_ref_i));
      check("ref_q", longint'(bus.ref_q), longint'(exp_ref_q));
      check("fbo_i", longint'(bus.fbo_i), longint'(exp_fbo_i));
      check("fbo_q", longint'(bus.fbo_q), longint'(exp_fbo_q));
      if (align_eq) begin
        check("ref_eq_fbo_i", longint'(bus.ref_i), longint'(bus.fbo_i));
        check("ref_eq_fbo_q", longint'(bus.ref_q), longint'(bus.fbo_q));
      end
    end
  end

  // ---------------- sequence helpers ----------------
  task automatic pulse_start();
    start_req = 1'b1;
    cyc(1);
    start_req = 1'b0;
  endtask

  task automatic wait_done(string tag, output bit ok);
    int waited = 0;
    while (bus.done !== 1'b1 && waited < SEARCH_LAT + 4) begin
      cyc(1);
      waited++;
    end
    ok = (bus.done === 1'b1);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_done: got no done pulse, expected one within %0d cycles", tag, SEARCH_LAT + 4);
    end
  endtask

  task automatic finish_search(string tag, int lag_lit, bit lock_lit);
    bit ok;
    wait_done(tag, ok);
    if (ok) begin
      check({tag, "_lag"},   longint'(bus.lag),  longint'(lag_lit));
      check({tag, "_lock"},  longint'(bus.lock), longint'(lock_lit));
      check({tag, "_model"}, longint'(exp_lag),  longint'(lag_lit));
    end
    $display("search %s: lag=%0d lock=%0d model_lag=%0d model_lock=%0d best=%0d",
             tag, bus.lag, bus.lock, exp_lag, exp_lock, last_best);
  endtask

  task automatic run_search(string tag, int lag_lit, bit lock_lit);
    cyc(MAX_LAG + 4);
    pulse_start();
    finish_search(tag, lag_lit, lock_lit);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.tx_i  = '0;
    bus.tx_q  = '0;
    bus.fb_i  = '0;
    bus.fb_q  = '0;
    cyc(5);
    rst_req = 1'b0;
    cyc(1);
    chk_en = 1'b1;
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_lag",  longint'(bus.lag),  0);
    check("rst_lock", longint'(bus.lock), 0);

    mode = M_PRBS; dly = 17;
    run_search("delay17", 17, 1'b1);
    cyc(4);
    align_eq = 1'b1;
    cyc(200);
    align_eq = 1'b0;

    mode = M_ZERO;
    run_search("fb_zero", 17, 1'b0);

    mode = M_ROT; dly = 5;
    run_search("rot90_d5", 5, 1'b1);

    mode = M_PRBS; dly = 0;
    run_search("delay0", 0, 1'b1);

    dly = 63;
    run_search("delay63", 63, 1'b1);
    cyc(4);
    align_eq = 1'b1;
    cyc(100);
    align_eq = 1'b0;

    mode = M_PER; dly = 3;
    run_search("periodic8", 3, 1'b1);

    // start re-pulsed while busy must not restart the search
    mode = M_PRBS; dly = 23;
    cyc(MAX_LAG + 4);
    pulse_start();
    cyc(WIN + MAX_LAG + 500);
    pulse_start();
    finish_search("restart_ign", 23, 1'b1);
    cyc(50);

    // reset in the middle of a search
    dly = 40;
    cyc(MAX_LAG + 4);
    pulse_start();
    cyc(WIN + MAX_LAG + 1000);
    rst_req = 1'b1;
    cyc(1);
    rst_req = 1'b0;
    cyc(1);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_lag",  longint'(bus.lag),  0);
    check("abort_lock", longint'(bus.lock), 0);

    dly = 9;
    run_search("fresh_d9", 9, 1'b1);
    cyc(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
